// File: rtl/signal_ramp_applier_pkg.sv
// Shared ramp definitions: state codes and envelope scaling constants,
// common to the ramp generator and the ramp applier.
package signal_ramp_applier_pkg;

  typedef enum logic [1:0] {
    NORMAL    = 2'b00,
    DONE      = 2'b01,
    RAMP_UP   = 2'b10,
    RAMP_DOWN = 2'b11
  } ramp_state_e;

  localparam int RAMP_FRAC_DEFAULT = 13;
  localparam int RAMP_UNITY        = (1 << RAMP_FRAC_DEFAULT) - 1;

  // True while the envelope is moving in either direction.
  function automatic logic is_ramping(input ramp_state_e s);
    return (s == RAMP_UP) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/signal_ramp_applier_scale_pipe.sv
// Three-stage envelope scaler: clamp the envelope, multiply, then
// round half up, saturate and zero the sample once the ramp is DONE.
module ramp_scale_pipe
  import signal_ramp_applier_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RAMP_FRAC  = RAMP_FRAC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_vld,
  input  logic        [15:0]           ramp,
  input  ramp_state_e                  state_in,
  output ramp_state_e                  state_s1,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_vld
);

  localparam int ENV_W  = RAMP_FRAC + 1;
  localparam int PROD_W = DATA_WIDTH + ENV_W;
  localparam logic [ENV_W-1:0]         UNITY = ENV_W'((1 << RAMP_FRAC) - 1);
  localparam logic signed [PROD_W-1:0] HALF  = PROD_W'(1 << (RAMP_FRAC - 1));
  localparam logic signed [PROD_W-1:0] MAXV  = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] MINV  = -MAXV - PROD_W'(1);

  // Anything above unity (including negative codes seen as unsigned) is unity.
  function automatic logic [ENV_W-1:0] clamp_env(input logic [15:0] r);
    if (r > 16'((1 << RAMP_FRAC) - 1)) return UNITY;
    else                               return r[ENV_W-1:0];
  endfunction

  // Signed sample times unsigned envelope.
  function automatic logic signed [PROD_W-1:0] scale(input logic signed [DATA_WIDTH-1:0] s,
                                                     input logic [ENV_W-1:0] e);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'(s);
    b = $signed({{(PROD_W - ENV_W){1'b0}}, e});
    return a * b;
  endfunction

  // Round half up, then saturate to the sample range.
  function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] r;
    r = (p + HALF) >>> RAMP_FRAC;
    if (r > MAXV)      return MAXV[DATA_WIDTH-1:0];
    else if (r < MINV) return MINV[DATA_WIDTH-1:0];
    else               return r[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] data_p1, data_p2;
  logic        [ENV_W-1:0]      env_p1;
  logic                         vld_p1, vld_p2;
  ramp_state_e                  state_p1, state_p2;
  logic signed [PROD_W-1:0]     prod_p2;
  logic                         bypass_p2;

  // ---- S1: capture sample, valid, clamped envelope and state
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      data_p1  <= '0;
      env_p1   <= '0;
      vld_p1   <= 1'b0;
      state_p1 <= NORMAL;
    end else begin
      data_p1  <= s_data;
      env_p1   <= clamp_env(ramp);
      vld_p1   <= s_vld;
      state_p1 <= state_in;
    end
  end

  // ---- S2: product, with unity flagged so the sample passes bit-exact
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prod_p2   <= '0;
      data_p2   <= '0;
      bypass_p2 <= 1'b0;
      vld_p2    <= 1'b0;
      state_p2  <= NORMAL;
    end else begin
      prod_p2   <= scale(data_p1, env_p1);
      data_p2   <= data_p1;
      bypass_p2 <= (env_p1 == UNITY);
      vld_p2    <= vld_p1;
      state_p2  <= state_p1;
    end
  end

  // ---- S3: round/clip or bypass, forced to zero when the aligned state is DONE
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_data <= '0;
      m_vld  <= 1'b0;
    end else begin
      m_vld <= vld_p2;
      if (state_p2 == DONE) m_data <= '0;
      else if (bypass_p2)   m_data <= data_p2;
      else                  m_data <= round_sat(prod_p2);
    end
  end

  assign state_s1 = state_p1;

endmodule

// File: rtl/signal_ramp_applier.sv
// Applies the ramp envelope to the DAC sample stream and reports
// ramp-down length and completion to the register bank.
module signal_ramp_applier
  import signal_ramp_applier_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RAMP_FRAC  = RAMP_FRAC_DEFAULT,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic        [15:0]           ramp,
  input  logic        [1:0]            rampState,
  input  logic                         clearStatus,
  output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         rampActive,
  output logic                         rampDoneSticky,
  output logic        [CNT_WIDTH-1:0]  rampDownCycles
);

  ramp_state_e state_s1;
  logic        down_prev;

  ramp_scale_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAMP_FRAC (RAMP_FRAC)
  ) u_pipe (
    .clk     (clk),
    .aresetn (aresetn),
    .s_data  (s_axis_tdata),
    .s_vld   (s_axis_tvalid),
    .ramp    (ramp),
    .state_in(ramp_state_e'(rampState)),
    .state_s1(state_s1),
    .m_data  (m_axis_tdata),
    .m_vld   (m_axis_tvalid)
  );

  // Ramp-down length: restart at 1 on entry, count up saturating, hold otherwise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rampDownCycles <= '0;
      down_prev      <= 1'b0;
    end else begin
      down_prev <= (state_s1 == RAMP_DOWN);
      if (state_s1 == RAMP_DOWN) begin
        if (!down_prev)                rampDownCycles <= CNT_WIDTH'(1);
        else if (rampDownCycles != '1) rampDownCycles <= rampDownCycles + CNT_WIDTH'(1);
      end
    end
  end

  // Activity flag and completion sticky; a DONE cycle beats a same-cycle clear.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rampActive     <= 1'b0;
      rampDoneSticky <= 1'b0;
    end else begin
      rampActive <= is_ramping(state_s1);
      if (state_s1 == DONE) rampDoneSticky <= 1'b1;
      else if (clearStatus) rampDoneSticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_signal_ramp_applier.sv
// Bench for signal_ramp_applier: per-cycle comparison against a
// cycle-history reference model, plus literal spot checks.
module tb_signal_ramp_applier;

  localparam logic [1:0] ST_N = 2'b00, ST_DONE = 2'b01, ST_UP = 2'b10, ST_DOWN = 2'b11;

  logic               clk = 1'b0;
  logic               aresetn;
  logic signed [15:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic        [15:0] ramp;
  logic        [1:0]  rampState;
  logic               clearStatus;
  logic signed [15:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               rampActive;
  logic               rampDoneSticky;
  logic        [31:0] rampDownCycles;

  always #5 clk = ~clk;

  signal_ramp_applier dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .ramp          (ramp),
    .rampState     (rampState),
    .clearStatus   (clearStatus),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .rampActive    (rampActive),
    .rampDoneSticky(rampDoneSticky),
    .rampDownCycles(rampDownCycles)
  );

  // One entry per clock of applied input; rd is the length of the latest
  // RAMP_DOWN run seen in the input stream up to and including this entry.
  typedef struct {
    int         sample;
    bit         valid;
    int         rmp;
    logic [1:0] st;
    bit         clr;
    longint     rd;
  } ent_t;

  typedef struct {
    int         s;
    int         r;
    logic [1:0] st;
    bit         v;
    int         e;
  } vec_t;

  ent_t hist[$];
  bit   stk_m;
  int   n_cmp = 0;
  int   n_bad = 0;

  vec_t vt [12] = '{
    '{32767,  8191,  ST_N,  1'b1, 32767},
    '{-32768, 8191,  ST_N,  1'b1, -32768},
    '{1234,   8191,  ST_N,  1'b1, 1234},
    '{16384,  4096,  ST_UP, 1'b1, 8192},
    '{-1,     4096,  ST_UP, 1'b1, 0},
    '{32767,  0,     ST_UP, 1'b1, 0},
    '{1000,   65535, ST_UP, 1'b1, 1000},
    '{1000,   9000,  ST_N,  1'b1, 1000},
    '{-32768, 8190,  ST_UP, 1'b1, -32760},
    '{3,      4096,  ST_UP, 1'b1, 2},
    '{7,      8191,  ST_N,  1'b0, 0},
    '{-5,     8191,  ST_N,  1'b1, -5}
  };

  // Output value that the envelope rules demand for one input sample.
  function automatic int model_out(int s, int r, logic [1:0] st);
    longint p;
    int     env;
    if (st == ST_DONE) return 0;
    env = (r > 8191) ? 8191 : r;
    if (env == 8191) return s;
    p = (longint'(s) * env + 4096) >>> 13;
    if (p > 32767)  return 32767;
    if (p < -32768) return -32768;
    return int'(p);
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // History as seen right after reset: pipeline empty, state NORMAL.
  task automatic pad();
    hist.delete();
    repeat (3) hist.push_back('{0, 1'b0, 0, ST_N, 1'b0, 64'd0});
    stk_m = 1'b0;
  endtask

  // Record this cycle's inputs, compare all outputs mid-cycle, advance one clock.
  task automatic cycle();
    ent_t e, p;
    int   n;
    if (hist.size() > 8) void'(hist.pop_front());
    p        = hist[hist.size()-1];
    e.sample = int'(s_axis_tdata);
    e.valid  = s_axis_tvalid;
    e.rmp    = int'(ramp);
    e.st     = rampState;
    e.clr    = clearStatus;
    if (e.st == ST_DOWN) e.rd = (p.st == ST_DOWN) ? ((p.rd < 64'hFFFFFFFF) ? p.rd + 1 : p.rd) : 1;
    else                 e.rd = p.rd;
    hist.push_back(e);
    n = hist.size();
    stk_m = (hist[n-3].st == ST_DONE) || (stk_m && !hist[n-2].clr);
    @(negedge clk);
    chk("tvalid", m_axis_tvalid, hist[n-4].valid);
    if (hist[n-4].valid || hist[n-4].st == ST_DONE)
      chk("tdata", m_axis_tdata, model_out(hist[n-4].sample, hist[n-4].rmp, hist[n-4].st));
    chk("rampActive", rampActive, (hist[n-3].st == ST_UP) || (hist[n-3].st == ST_DOWN));
    chk("rampDownCycles", rampDownCycles, hist[n-3].rd);
    chk("rampDoneSticky", rampDoneSticky, stk_m);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int s, int r, logic [1:0] st, bit v);
    s_axis_tdata  = 16'(s);
    ramp          = 16'(r);
    rampState     = st;
    s_axis_tvalid = v;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_active"}, rampActive, 0);
    chk({tag, "_sticky"}, rampDoneSticky, 0);
    chk({tag, "_cycles"}, rampDownCycles, 0);
  endtask

  initial begin
    int runleft;
    logic [1:0] st_r;

    aresetn     = 1'b0;
    clearStatus = 1'b0;
    drive(0, 0, ST_N, 1'b0);
    #3;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1;
    pad();

    // Directed vectors; after call i the output belongs to vector i-2.
    for (int i = 0; i < 15; i++) begin
      if (i < 12) drive(vt[i].s, vt[i].r, vt[i].st, vt[i].v);
      else        drive(0, 8191, ST_N, 1'b0);
      cycle();
      if (i >= 2 && i - 2 < 12) begin
        chk("lit_tvalid", m_axis_tvalid, vt[i-2].v);
        if (vt[i-2].v) chk("lit_tdata", m_axis_tdata, vt[i-2].e);
      end
      if (i == 2) chk("lit_active_normal", rampActive, 0);
      if (i == 5) chk("lit_active_up", rampActive, 1);
    end

    // Full ramp-down: 8192 cycles, then DONE with a live sample at unity.
    repeat (4) begin drive(5000, 8191, ST_N, 1'b1); cycle(); end
    for (int i = 0; i < 8192; i++) begin
      drive(5000, 8191 - i, ST_DOWN, 1'b1);
      cycle();
      if (i == 10) chk("lit_active_down", rampActive, 1);
    end
    drive(5000, 8191, ST_DONE, 1'b1);
    cycle();
    chk("lit_sticky_before", rampDoneSticky, 0);
    chk("lit_down_cycles", rampDownCycles, 8192);
    cycle();
    chk("lit_sticky_set", rampDoneSticky, 1);
    chk("lit_active_done", rampActive, 0);
    cycle();
    chk("lit_forced_zero", m_axis_tdata, 0);
    chk("lit_forced_valid", m_axis_tvalid, 1);
    clearStatus = 1'b1;
    cycle();
    clearStatus = 1'b0;
    chk("lit_set_wins", rampDoneSticky, 1);
    drive(5000, 8191, ST_N, 1'b1);
    repeat (3) cycle();
    chk("lit_sticky_held", rampDoneSticky, 1);
    clearStatus = 1'b1;
    cycle();
    clearStatus = 1'b0;
    chk("lit_sticky_cleared", rampDoneSticky, 0);
    chk("lit_cycles_held", rampDownCycles, 8192);

    // Asynchronous reset in the middle of a ramp-down with valid data in flight.
    repeat (2) begin drive(1111, 8191, ST_N, 1'b1); cycle(); end
    for (int i = 0; i < 40; i++) begin drive(2000 + i, 6000, ST_DOWN, 1'b1); cycle(); end
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); @(posedge clk); #1;
    aresetn = 1'b1;
    pad();
    drive(3000, 8191, ST_DOWN, 1'b1);
    cycle();
    chk("lit_rst_tvalid1", m_axis_tvalid, 0);
    cycle();
    chk("lit_rst_tvalid2", m_axis_tvalid, 0);
    cycle();
    chk("lit_rst_tvalid3", m_axis_tvalid, 1);
    chk("lit_rst_cycles", rampDownCycles, 2);

    // Randomized traffic: state runs, mixed envelopes, sporadic clears.
    runleft = 0;
    st_r    = ST_N;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (runleft == 0) begin
        st_r    = 2'($urandom_range(0, 3));
        runleft = $urandom_range(1, 24);
      end
      runleft--;
      case ($urandom_range(0, 9))
        0:       r = 8191;
        1, 2:    r = $urandom_range(0, 65535);
        3:       r = 0;
        default: r = $urandom_range(0, 8191);
      endcase
      drive(($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                        : int'(16'($urandom)),
            r, st_r, $urandom_range(0, 3) != 0);
      clearStatus = ($urandom_range(0, 9) == 0);
      cycle();
    end
    clearStatus = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signal_ramp_applier.md
Name: signal_ramp_applier

Overview:
- Downstream consumer of the ramp generator's `ramp` envelope and `rampState` code. Multiplies each DAC sample by the envelope.
- Unity is encoded as 8191; envelope values run 0..8191.
- Forces the DAC output to zero once ramp-down completes.
- Reports ramp-down duration and completion status to the register bank.
- Sits between the waveform sum stage and the DAC output formatter in each channel.

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement).
- RAMP_FRAC, 13, fractional bits of the envelope; unity = 2^RAMP_FRAC - 1.
- CNT_WIDTH, 32, width of the ramp-down cycle counter.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  signed input sample.
- s_axis_tvalid  in  1  input sample valid; no backpressure.
- ramp  in  16  envelope value from the ramp generator; nominal range 0..8191.
- rampState  in  2  ramp generator state code.
- clearStatus  in  1  single-cycle pulse; clears rampDoneSticky.
- m_axis_tdata  out  DATA_WIDTH  scaled output sample.
- m_axis_tvalid  out  1  output valid.
- rampActive  out  1  high while the aligned state is RAMP_UP or RAMP_DOWN.
- rampDoneSticky  out  1  set when DONE is reached; held until cleared.
- rampDownCycles  out  CNT_WIDTH  length in cycles of the most recent ramp-down.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (aresetn). On assertion, all pipeline registers and all outputs are 0 immediately.
- Pipeline: fixed 3-cycle latency, no stalls; every stage advances every clk.
  - S1 registers sample, valid, ramp and rampState.
  - S2 computes the product.
  - S3 rounds, clips and applies force-zero, then registers the outputs.
- Valid handling: m_axis_tvalid = s_axis_tvalid delayed 3 cycles. Data in invalid slots is still computed; its value is don't-care except that force-zero applies.
- Envelope clamp: in S1, ramp > 8191, including negative values read as unsigned, clamps to 8191.
- Product: signed sample x unsigned 14-bit envelope gives a 30-bit signed product.
  - If the envelope is 8191, bypass: output = sample exactly.
  - Otherwise output = (product + 4096) >>> 13, i.e. round half up.
- Clip: result saturates to [-32768, 32767]. This is unreachable for legal inputs but must still be implemented.
- Force zero: if the rampState aligned with the sample (S1 copy carried to S3) is DONE, m_axis_tdata = 0.
- rampActive: registered from the S1 state. It is high for RAMP_UP or RAMP_DOWN.
- rampDownCycles counter, driven by the S1 state:
  - On the first cycle of RAMP_DOWN following any other state, load 1.
  - On each following RAMP_DOWN cycle, increment, saturating at all-ones.
  - In any other state, hold the value.
  - A new ramp-down overwrites the previous value.
- rampDoneSticky:
  - Set on any cycle where the S1 state is DONE.
  - clearStatus clears it.
  - If set and clear occur on the same cycle, set wins.
- Mid-operation reset: the pipeline flushes and outputs go to 0. No stale valid appears after release. The first m_axis_tvalid can appear no earlier than 3 cycles after the first sampled valid.

Decomposition:
- Shared package holds:
  - rampState codes: RAMP_UP=2'b10, NORMAL=2'b00, RAMP_DOWN=2'b11, DONE=2'b01.
  - Unity constant: 8191.
  - RAMP_FRAC default.
  - These are also adopted by the ramp generator.
- One sub-module: ramp_scale_pipe. It covers the 3-stage clamp/multiply/round/clip datapath with valid and state sidebands.
- The counter and status logic stay in the top module.

Test Plan:
- Reset then NORMAL: ramp=8191, samples 32767, -32768, 1234 -> outputs identical 3 cycles later; tvalid pattern delayed 3; rampActive=0.
- Scaling: RAMP_UP, sample=16384, ramp=4096 -> 8192. Sample=-1, ramp=4096 -> 0 (round half up). Sample=32767, ramp=0 -> 0.
- Clamp: ramp=16'hFFFF or 9000 with sample=1000 -> 1000 (bypass).
- Ramp-down: NORMAL, then RAMP_DOWN for 8192 cycles, then DONE.
  - Expect rampDownCycles=8192 and rampActive high during the ramp-down.
  - rampDoneSticky rises when DONE reaches S1.
  - Output forced to 0 from the aligned DONE sample, with input 5000 still applied.
- Status: with DONE held, pulse clearStatus -> sticky stays 1 (set wins). Return to NORMAL, pulse clearStatus -> 0.
- Async reset mid-ramp-down with valid samples in flight -> outputs 0 immediately, counter 0. After release, no m_axis_tvalid for 3 cycles after the first input valid.
